// File: rtl/cblock_cfg.sv
// cblock_cfg: serially configured connection block joining a W-track channel to up/down logic-block pins
module cblock_cfg #(
  parameter int W = 3,
  parameter int SEL_W = $clog2(W + 1),
  parameter int CFG_BITS = 2 * W + 2 * SEL_W
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         cfg_en_i,
  input  logic         cfg_valid_i,
  input  logic         cfg_bit_i,
  output logic         cfg_bit_o,
  output logic         cfg_done_o,
  output logic         cfg_err_o,
  input  logic [W-1:0] chan_i,
  output logic [W-1:0] chan_o,
  input  logic         up_i,
  output logic         up_o,
  input  logic         down_i,
  output logic         down_o
);
  localparam int CW = $clog2(CFG_BITS + 1);
  localparam int P = 1 << SEL_W;
  typedef enum logic [1:0] {UNCFG, LOAD, ACTIVE} state_t;
  state_t state, nxt;
  logic [CFG_BITS-1:0] shadow, act;
  logic [CW-1:0] cnt;
  logic [SEL_W-1:0] up_sel, down_sel;
  logic [P-1:0] chan_pad;
  logic shift, full, close;
  assign shift = cfg_en_i & cfg_valid_i;
  assign full = cnt == CW'(CFG_BITS);
  assign close = state == LOAD && !cfg_en_i;
  assign cfg_bit_o = shadow[CFG_BITS-1];
  assign up_sel = act[CFG_BITS-1 -: SEL_W];
  assign down_sel = act[CFG_BITS-1-SEL_W -: SEL_W];
  // Zero-padding past W makes out-of-range selects read 0.
  assign chan_pad = P'(chan_i);
  assign up_o = cfg_done_o & chan_pad[up_sel];
  assign down_o = cfg_done_o & chan_pad[down_sel];
  for (genvar k = 0; k < W; k++) begin : g_trk
    logic [1:0] m;
    assign m = act[2*k +: 2];
    assign chan_o[k] = cfg_done_o & (m == 2'd0 ? chan_i[k] : m == 2'd1 ? up_i : m == 2'd2 ? down_i : 1'b0);
  end
  // Next state: a window closing commits or falls back depending on prior configuration.
  always_comb begin
    nxt = state;
    if (state == LOAD)
      nxt = cfg_en_i ? LOAD : (full || cfg_done_o) ? ACTIVE : UNCFG;
    else if (cfg_en_i)
      nxt = LOAD;
  end
  // Shadow shifting and atomic commit into the active register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= UNCFG;
      shadow <= '0;
      act <= '0;
      cnt <= '0;
      cfg_done_o <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      state <= nxt;
      if (shift) begin
        shadow <= {shadow[CFG_BITS-2:0], cfg_bit_i};
        cnt <= full ? cnt : cnt + 1'b1;
      end
      if (close) begin
        cnt <= '0;
        cfg_err_o <= !full;
        if (full) begin
          act <= shadow;
          cfg_done_o <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cblock_cfg.sv
// tb_cblock_cfg: directed checks of configuration load, commit, reject, chaining and reset
module tb_cblock_cfg;
  logic clk = 1'b0, reset, en, valid, bit_in, up, down;
  logic [2:0] chan;
  logic a_bit, a_done, a_err, a_up, a_down;
  logic b_bit, b_done, b_err, b_up, b_down;
  logic [2:0] a_chan, b_chan;
  int total = 0, bad = 0;
  logic [19:0] cw;
  always #5 clk = ~clk;
  cblock_cfg #(.W(3)) u_a (
    .clk_i(clk), .reset_i(reset), .cfg_en_i(en), .cfg_valid_i(valid), .cfg_bit_i(bit_in),
    .cfg_bit_o(a_bit), .cfg_done_o(a_done), .cfg_err_o(a_err), .chan_i(chan), .chan_o(a_chan),
    .up_i(up), .up_o(a_up), .down_i(down), .down_o(a_down)
  );
  cblock_cfg #(.W(3)) u_b (
    .clk_i(clk), .reset_i(reset), .cfg_en_i(en), .cfg_valid_i(valid), .cfg_bit_i(a_bit),
    .cfg_bit_o(b_bit), .cfg_done_o(b_done), .cfg_err_o(b_err), .chan_i(chan), .chan_o(b_chan),
    .up_i(up), .up_o(b_up), .down_i(down), .down_o(b_down)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic shift(input logic [19:0] w, input int n, input bit gap, input bit hold, input logic [2:0] hv);
    en = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      if (gap) begin
        valid = 1'b0;
        bit_in = ~w[i];
        step;
        if (hold) chk("hold_gap", a_chan, hv);
      end
      valid = 1'b1;
      bit_in = w[i];
      step;
      if (hold) chk("hold_shift", a_chan, hv);
    end
    valid = 1'b0;
  endtask
  task automatic close;
    en = 1'b0;
    step;
  endtask
  initial begin
    reset = 1'b1; en = 1'b0; valid = 1'b0; bit_in = 1'b0;
    chan = 3'b111; up = 1'b1; down = 1'b1;
    step;
    step;
    chk("rst_chan", a_chan, 3'b000);
    chk("rst_up", a_up, 1'b0);
    chk("rst_down", a_down, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_bit", a_bit, 1'b0);
    reset = 1'b0;
    chan = 3'b110; up = 1'b0; down = 1'b1;
    shift(20'b1000010010, 10, 1'b0, 1'b1, 3'b000);
    chk("unconf_load_up", a_up, 1'b0);
    close;
    chk("full_up", a_up, 1'b1);
    chk("full_down", a_down, 1'b0);
    chk("full_chan", a_chan, 3'b011);
    chk("full_done", a_done, 1'b1);
    chk("full_err", a_err, 1'b0);
    shift(20'h7f, 7, 1'b0, 1'b1, 3'b011);
    close;
    chk("short_err", a_err, 1'b1);
    chk("short_done", a_done, 1'b1);
    chk("short_chan", a_chan, 3'b011);
    chk("short_up", a_up, 1'b1);
    shift(20'b0001110001, 10, 1'b1, 1'b1, 3'b011);
    close;
    chk("glitch_chan", a_chan, 3'b010);
    chk("glitch_up", a_up, 1'b0);
    chk("glitch_down", a_down, 1'b1);
    chk("glitch_err", a_err, 1'b0);
    chan = 3'b101; up = 1'b0; down = 1'b1;
    cw = {10'b1110100111, 10'b0100001001};
    en = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      valid = 1'b1;
      bit_in = cw[20-j];
      if (j > 10) chk("chain_out", a_bit, cw[30-j]);
      step;
    end
    valid = 1'b0;
    close;
    chk("chain_a_chan", a_chan, 3'b110);
    chk("chain_a_up", a_up, 1'b0);
    chk("chain_a_down", a_down, 1'b1);
    chk("chain_b_chan", b_chan, 3'b100);
    chk("chain_b_up", b_up, 1'b0);
    chk("chain_b_down", b_down, 1'b1);
    chk("chain_b_done", b_done, 1'b1);
    shift(20'b10110, 5, 1'b0, 1'b0, 3'b000);
    reset = 1'b1; en = 1'b0;
    chan = 3'b111; up = 1'b1; down = 1'b1;
    step;
    reset = 1'b0;
    chk("mid_rst_chan", a_chan, 3'b000);
    chk("mid_rst_up", a_up, 1'b0);
    chk("mid_rst_down", a_down, 1'b0);
    chk("mid_rst_done", a_done, 1'b0);
    chk("mid_rst_err", a_err, 1'b0);
    chk("mid_rst_bit", a_bit, 1'b0);
    chan = 3'b110; up = 1'b0; down = 1'b1;
    shift(20'b1000010010, 10, 1'b0, 1'b0, 3'b000);
    close;
    chk("reload_chan", a_chan, 3'b011);
    chk("reload_up", a_up, 1'b1);
    chk("reload_down", a_down, 1'b0);
    chk("reload_done", a_done, 1'b1);
    chk("reload_err", a_err, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
